// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - PC fetch sequencer: imem req/ack, valid/ready instruction hold, redirect and fault trap
module pc_fetch_ctrl #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          MAX_WAIT = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_plus4_o,
  input  logic        instr_ready_i,
  input  logic        redir_valid_i,
  input  logic [1:0]  redir_sel_i,
  input  logic [31:0] branch_offset_i,
  input  logic [25:0] jump_target_i,
  input  logic [31:0] jr_addr_i,
  output logic        fault_o,
  output logic [1:0]  fault_code_o
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_HOLD  = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      state;
  logic [31:0] pc;
  logic [7:0]  wait_cnt;
  logic [31:0] next_pc;
  logic        jr_misaligned;

  // Redirect target is formed from the held instruction's PC+4, not the live PC.
  always_comb begin
    next_pc       = pc_plus4_o;
    jr_misaligned = 1'b0;
    if (redir_valid_i) begin
      case (redir_sel_i)
        2'b00: next_pc = pc_plus4_o + (branch_offset_i << 2);
        2'b01: next_pc = {pc_plus4_o[31:28], jump_target_i, 2'b00};
        2'b10: begin
          next_pc       = jr_addr_i;
          jr_misaligned = (jr_addr_i[1:0] != 2'b00);
        end
        default: next_pc = pc_plus4_o;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state        <= S_REQ;
      pc           <= PC_RESET;
      instr_o      <= 32'h0;
      pc_plus4_o   <= 32'h0;
      wait_cnt     <= 8'h0;
      fault_o      <= 1'b0;
      fault_code_o <= 2'b00;
    end else begin
      case (state)
        S_REQ: begin
          if (imem_ack_i) begin
            instr_o    <= imem_data_i;
            pc_plus4_o <= pc + 32'd4;
            wait_cnt   <= 8'h0;
            state      <= S_HOLD;
          end else if (wait_cnt == WAIT_LAST) begin
            fault_o      <= 1'b1;
            fault_code_o <= 2'b10;
            state        <= S_FAULT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_HOLD: begin
          if (instr_ready_i) begin
            if (jr_misaligned) begin
              fault_o      <= 1'b1;
              fault_code_o <= 2'b01;
              state        <= S_FAULT;
            end else begin
              pc    <= next_pc;
              state <= S_REQ;
            end
          end
        end
        default: state <= S_FAULT;
      endcase
    end
  end

  assign imem_req_o    = (state == S_REQ);
  assign instr_valid_o = (state == S_HOLD);
  assign imem_addr_o   = pc;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - randomized self-checking bench for pc_fetch_ctrl
module tb_pc_fetch_ctrl;

  localparam logic [31:0] PC_RESET = 32'h0000_0000;
  localparam int          MAX_WAIT = 15;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_plus4_o;
  logic        instr_ready_i;
  logic        redir_valid_i;
  logic [1:0]  redir_sel_i;
  logic [31:0] branch_offset_i;
  logic [25:0] jump_target_i;
  logic [31:0] jr_addr_i;
  logic        fault_o;
  logic [1:0]  fault_code_o;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_pc;
  logic        m_fault;
  logic [1:0]  m_code;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(.PC_RESET(PC_RESET), .MAX_WAIT(MAX_WAIT)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .pc_plus4_o(pc_plus4_o),
    .instr_ready_i(instr_ready_i), .redir_valid_i(redir_valid_i),
    .redir_sel_i(redir_sel_i), .branch_offset_i(branch_offset_i),
    .jump_target_i(jump_target_i), .jr_addr_i(jr_addr_i),
    .fault_o(fault_o), .fault_code_o(fault_code_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_ack_i      = 1'b0;
    imem_data_i     = 32'h0;
    instr_ready_i   = 1'b0;
    redir_valid_i   = 1'b0;
    redir_sel_i     = 2'b11;
    branch_offset_i = 32'h0;
    jump_target_i   = 26'h0;
    jr_addr_i       = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b0;
    step();
    rst_i   = 1'b1;
    m_pc    = PC_RESET;
    m_fault = 1'b0;
    m_code  = 2'b00;
    check("rst_instr", instr_o, 32'h0);
    check("rst_pp4", pc_plus4_o, 32'h0);
    check("rst_fault", {31'h0, fault_o}, 32'h0);
    check("rst_code", {30'h0, fault_code_o}, 32'h0);
    check("rst_valid", {31'h0, instr_valid_o}, 32'h0);
  endtask

  task automatic check_req_cycle(input string tag);
    check({tag, "_req"}, {31'h0, imem_req_o}, 32'h1);
    check({tag, "_addr"}, imem_addr_o, m_pc);
    check({tag, "_valid"}, {31'h0, instr_valid_o}, 32'h0);
    check({tag, "_fault"}, {31'h0, fault_o}, 32'h0);
  endtask

  task automatic check_fault(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      imem_ack_i    = 1'($urandom);
      instr_ready_i = 1'($urandom);
      check("flt_fault", {31'h0, fault_o}, 32'h1);
      check("flt_code", {30'h0, fault_code_o}, {30'h0, m_code});
      check("flt_req", {31'h0, imem_req_o}, 32'h0);
      check("flt_valid", {31'h0, instr_valid_o}, 32'h0);
      check("flt_addr", imem_addr_o, m_pc);
      step();
    end
    idle_inputs();
  endtask

  // One instruction as a transaction: ack after ack_dly no-ack cycles, accept after rdy_dly stall cycles.
  task automatic fetch(input int ack_dly, input int rdy_dly, input logic [31:0] data,
                       input logic rv, input logic [1:0] sel, input logic [31:0] off,
                       input logic [25:0] tgt, input logic [31:0] jr);
    logic [31:0] pp4;
    for (int i = 0; i <= ack_dly; i++) begin
      imem_ack_i  = (i == ack_dly);
      imem_data_i = (i == ack_dly) ? data : ~data;
      check_req_cycle("fetch");
      step();
    end
    pp4 = m_pc + 32'd4;
    for (int j = 0; j <= rdy_dly; j++) begin
      imem_ack_i    = 1'($urandom);
      imem_data_i   = $urandom;
      instr_ready_i = (j == rdy_dly);
      if (j == rdy_dly) begin
        redir_valid_i = rv; redir_sel_i = sel; branch_offset_i = off;
        jump_target_i = tgt; jr_addr_i = jr;
      end else begin
        redir_valid_i = 1'b1; redir_sel_i = 2'b10; jr_addr_i = 32'h0000_0003;
      end
      check("hold_valid", {31'h0, instr_valid_o}, 32'h1);
      check("hold_req", {31'h0, imem_req_o}, 32'h0);
      check("hold_instr", instr_o, data);
      check("hold_pp4", pc_plus4_o, pp4);
      check("hold_addr", imem_addr_o, m_pc);
      step();
    end
    idle_inputs();
    if (!rv || sel == 2'b11) m_pc = pp4;
    else if (sel == 2'b00) m_pc = pp4 + off * 32'd4;
    else if (sel == 2'b01) m_pc = (pp4 & 32'hF000_0000) | ({6'h0, tgt} * 32'd4);
    else if (jr % 4 != 0) begin m_fault = 1'b1; m_code = 2'b01; end
    else m_pc = jr;
    if (m_fault) check_fault(3);
  endtask

  initial begin
    idle_inputs();
    rst_i = 1'b0;
    step();
    do_reset();

    fetch(0, 0, 32'hDEAD_0001, 1'b0, 2'b11, 0, 0, 0);
    check("seq_addr4", imem_addr_o, 32'h4);
    fetch(3, 2, 32'hDEAD_0002, 1'b0, 2'b11, 0, 0, 0);
    fetch(0, 0, 32'h1, 1'b1, 2'b10, 0, 0, 32'h1000_0010);
    fetch(1, 0, 32'h2, 1'b1, 2'b01, 0, 26'h0000123, 0);
    check("jump_addr", imem_addr_o, 32'h1000_048C);
    fetch(0, 0, 32'h3, 1'b1, 2'b10, 0, 0, 32'h0000_001C);
    fetch(0, 1, 32'h4, 1'b1, 2'b00, 32'hFFFF_FFFC, 0, 0);
    check("branch_back", imem_addr_o, 32'h10);
    fetch(0, 0, 32'h5, 1'b1, 2'b10, 0, 0, 32'hFFFF_FFF8);
    fetch(0, 0, 32'h6, 1'b1, 2'b00, 32'h1, 0, 0);
    check("branch_wrap", imem_addr_o, 32'h0);
    fetch(0, 0, 32'h7, 1'b1, 2'b10, 0, 0, 32'h40);
    check("jr_aligned", imem_addr_o, 32'h40);
    fetch(MAX_WAIT - 1, 0, 32'h8, 1'b0, 2'b00, 0, 0, 0);
    fetch(2, 3, 32'h9, 1'b1, 2'b10, 0, 0, 32'h0000_0042);
    check("jr_mis_code", {30'h0, fault_code_o}, 32'h1);
    do_reset();

    for (int i = 0; i < MAX_WAIT; i++) begin
      check_req_cycle("tmo");
      step();
    end
    m_fault = 1'b1; m_code = 2'b10;
    check_fault(3);
    do_reset();

    for (int i = 0; i < 5; i++) begin
      check_req_cycle("midwait");
      step();
    end
    do_reset();
    check_req_cycle("after_rst");

    for (int n = 0; n < 300; n++) begin
      logic [31:0] jr;
      int ad;
      jr = $urandom;
      if ($urandom_range(0, 15) != 0) jr[1:0] = 2'b00;
      ad = ($urandom_range(0, 7) == 0) ? $urandom_range(0, MAX_WAIT - 1) : $urandom_range(0, 2);
      fetch(ad, $urandom_range(0, 3), $urandom, 1'($urandom), 2'($urandom),
            32'($signed($urandom_range(0, 31)) - 16), 26'($urandom), jr);
      if (m_fault) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Fetch sequencer for the lab CPU: owns the PC register and drives instruction-memory requests with a req/ack handshake.
- Presents fetched instructions downstream with a valid/ready handshake.
- Computes the next PC: sequential PC+4, branch, jump ({PC+4[31:28], target26, 2'b00}) or jr, applied when the redirecting instruction is accepted.
- Traps misaligned jr targets and memory timeouts into a sticky fault state.

Parameters:
PC_RESET, 32'h0000_0000, PC value loaded on reset
MAX_WAIT, 15, max cycles in REQ without imem_ack_i before fault (1..255)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset; synchronous, active-low
imem_req_o  out  1  instruction memory request
imem_addr_o  out  32  request address (= PC)
imem_ack_i  in  1  memory returns imem_data_i this cycle
imem_data_i  in  32  fetched instruction word
instr_valid_o  out  1  instr_o/pc_plus4_o valid
instr_o  out  32  held instruction
pc_plus4_o  out  32  PC+4 of held instruction
instr_ready_i  in  1  downstream accepts held instruction
redir_valid_i  in  1  accepted instruction redirects flow
redir_sel_i  in  2  00 branch, 01 jump, 10 jr, 11 none
branch_offset_i  in  32  sign-extended branch immediate (word offset)
jump_target_i  in  26  jump instr_index field
jr_addr_i  in  32  jr register value
fault_o  out  1  sticky fault
fault_code_o  out  2  00 none, 01 misaligned jr, 10 mem timeout

Behaviour:
- States: REQ, HOLD, FAULT (2-bit register). Moore outputs except instr_o/pc_plus4_o/fault regs.
- Reset (rst_i=0 at clk edge): state=REQ, pc=PC_RESET, instr_o=0, pc_plus4_o=0, wait count=0, fault_o=0, fault_code_o=00. A reset mid-request abandons it; no ack is tracked afterward.
- REQ: imem_req_o=1, imem_addr_o=pc; address stable until ack. Ack in same cycle as req is legal.
  - On imem_ack_i: instr_o<=imem_data_i, pc_plus4_o<=pc+4, count<=0, state->HOLD.
  - Without ack: count++. If count reaches MAX_WAIT-1 without ack, fault_code=10 and state->FAULT.
- HOLD: instr_valid_o=1, imem_req_o=0, outputs stable until accept (instr_valid_o && instr_ready_i).
  - On accept, next pc:
    - redir_valid_i=0 or sel=11: pc_plus4_o.
    - sel=00: pc_plus4_o + (branch_offset_i<<2), mod 2^32, wrap permitted.
    - sel=01: {pc_plus4_o[31:28], jump_target_i, 2'b00}.
    - sel=10: jr_addr_i; if jr_addr_i[1:0]!=0, no pc update, fault_code=01, state->FAULT.
  - Otherwise state->REQ.
  - redir_* are ignored in any cycle without accept.
- FAULT: imem_req_o=0, instr_valid_o=0, fault_o=1, pc frozen; exit only via reset.
- imem_addr_o=pc in all states. imem_ack_i outside REQ is ignored.
- Throughput: 2 cycles/instruction minimum (REQ with ack, HOLD with ready).
- All arithmetic 32-bit unsigned, carry discarded.

Test Plan:
- Reset release, ack same cycle, ready=1 -> cycle0 req=1 addr=0x0; cycle1 valid=1 instr=data, pc_plus4=0x4; cycle2 req addr=0x4.
- Ack delayed 3 cycles, ready delayed 2 -> addr held 0x0 for 4 cycles; instr_o/pc_plus4 stable while valid&&!ready; no extra request.
- Instr at 0x1000_0010 accepted with sel=01, target=0x0000123 -> next addr 0x1000_048C. Branch at pc_plus4=0x20, offset=0xFFFF_FFFC -> next addr 0x10. Branch at pc_plus4=0xFFFF_FFFC, offset=1 -> 0x0000_0000 (wrap).
- jr with jr_addr_i=0x0000_0042 -> fault_o=1, code=01, req=0, valid=0 thereafter. Same with 0x40 -> next addr 0x40. redir_valid_i=1 while ready=0 -> ignored.
- MAX_WAIT=15, no ack -> req high exactly 15 cycles then fault code=10. rst_i=0 for one cycle during a wait -> next cycle REQ addr=PC_RESET, fault cleared.
